// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_e;

  localparam int unsigned LEAK_SHIFT_W = 3;

  // Width-generic saturating add: operands are zero-extended into 32 bits, w must be 1..32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << w) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron leaky integrate-and-fire update.
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]        v,
  input  logic [WIDTH-1:0]        pending,
  input  logic [WIDTH-1:0]        threshold,
  input  logic [LEAK_SHIFT_W-1:0] shift,
  input  logic                    refrac_active,
  output logic [WIDTH-1:0]        v_next,
  output logic                    spike
);

  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] sum;

  always_comb begin
    leaked = (shift == '0) ? v : v - (v >> shift);
    sum    = WIDTH'(sat_add(32'(leaked), 32'(pending), WIDTH));
    v_next = sum;
    spike  = 1'b0;
    // A refractory neuron is pinned at rest and cannot fire.
    if (refrac_active) begin
      v_next = '0;
    end else if (sum >= threshold) begin
      spike  = 1'b1;
      v_next = '0;
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps one LIF update datapath across N_NEURONS virtual neurons with indexed spike output.
// Optional refractory counters are enabled with the LIF_REFRACTORY_EN macro.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS     = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned REFRAC_SWEEPS = 2,
  localparam int unsigned IDX_W        = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic [WIDTH-1:0]        in_current,
  input  logic                    tick,
  input  logic [WIDTH-1:0]        cfg_threshold,
  input  logic [LEAK_SHIFT_W-1:0] cfg_leak_shift,
  output logic                    spk_valid,
  input  logic                    spk_ready,
  output logic [IDX_W-1:0]        spk_idx,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    overrun,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [WIDTH-1:0]        rd_state
);

  if (N_NEURONS < 2 || N_NEURONS > 16 || (N_NEURONS & (N_NEURONS - 1)) != 0 ||
      WIDTH < 1 || WIDTH > 32 || REFRAC_SWEEPS > 255) begin : g_param_check
    $error("lif_scheduler: unsupported parameter set");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] v_q    [N_NEURONS];
  logic [WIDTH-1:0] v_d    [N_NEURONS];
  logic [WIDTH-1:0] pend_q [N_NEURONS];
  logic [WIDTH-1:0] pend_d [N_NEURONS];
  logic             spk_valid_q, spk_valid_d;
  logic [IDX_W-1:0] spk_idx_q, spk_idx_d;
  logic             sweep_done_q, sweep_done_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] rd_state_q, rd_state_d;

  logic [WIDTH-1:0] upd_v_next;
  logic             upd_spike;
  logic             refrac_active;
  logic             stall;
  logic             do_update;

  // A full output buffer freezes the sweep so spikes leave strictly in index order.
  assign stall     = spk_valid_q && !spk_ready;
  assign do_update = (state_q == ST_SWEEP) && !stall;
  assign in_ready  = (state_q == ST_IDLE) && !tick;

  lif_update #(
    .WIDTH (WIDTH)
  ) u_update (
    .v             (v_q[ptr_q]),
    .pending       (pend_q[ptr_q]),
    .threshold     (cfg_threshold),
    .shift         (cfg_leak_shift),
    .refrac_active (refrac_active),
    .v_next        (upd_v_next),
    .spike         (upd_spike)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned RC_W = (REFRAC_SWEEPS < 1) ? 1 : $clog2(REFRAC_SWEEPS + 1);

  logic [RC_W-1:0] refrac_q [N_NEURONS];
  logic [RC_W-1:0] refrac_d [N_NEURONS];

  assign refrac_active = (refrac_q[ptr_q] != '0);

  always_comb begin
    refrac_d = refrac_q;
    if (do_update) begin
      if (refrac_active) begin
        refrac_d[ptr_q] = refrac_q[ptr_q] - RC_W'(1);
      end else if (upd_spike) begin
        refrac_d[ptr_q] = RC_W'(REFRAC_SWEEPS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        refrac_q[i] <= '0;
      end
    end else begin
      refrac_q <= refrac_d;
    end
  end
`else
  assign refrac_active = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    v_d          = v_q;
    pend_d       = pend_q;
    spk_valid_d  = spk_valid_q;
    spk_idx_d    = spk_idx_q;
    sweep_done_d = 1'b0;
    overrun_d    = overrun_q;
    rd_state_d   = v_q[rd_idx];

    if (spk_valid_q && spk_ready) begin
      spk_valid_d = 1'b0;
    end

    if (in_valid && in_ready) begin
      pend_d[in_idx] = WIDTH'(sat_add(32'(pend_q[in_idx]), 32'(in_current), WIDTH));
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (do_update) begin
          v_d[ptr_q]    = upd_v_next;
          pend_d[ptr_q] = '0;
          // A new spike reloads the buffer even on the edge that drains the old one.
          if (upd_spike) begin
            spk_valid_d = 1'b1;
            spk_idx_d   = ptr_q;
          end
          if (ptr_q == IDX_W'(N_NEURONS - 1)) begin
            state_d      = ST_IDLE;
            sweep_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      spk_valid_q  <= 1'b0;
      spk_idx_q    <= '0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_state_q   <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        v_q[i]    <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      spk_valid_q  <= spk_valid_d;
      spk_idx_q    <= spk_idx_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
      rd_state_q   <= rd_state_d;
      v_q          <= v_d;
      pend_q       <= pend_d;
    end
  end

  assign busy       = (state_q == ST_SWEEP);
  assign spk_valid  = spk_valid_q;
  assign spk_idx    = spk_idx_q;
  assign sweep_done = sweep_done_q;
  assign overrun    = overrun_q;
  assign rd_state   = rd_state_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: vector table, directed corner sequences, random sweeps vs a reference model.
module tb_lif_scheduler;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int IDX_W  = 2;
  localparam int MAXV   = 255;
  localparam int REFRAC = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx = '0;
  logic [W-1:0]     in_current = '0;
  logic             tick = 1'b0;
  logic [W-1:0]     cfg_threshold = 8'd255;
  logic [2:0]       cfg_leak_shift = 3'd0;
  logic             spk_valid;
  logic             spk_ready = 1'b1;
  logic [IDX_W-1:0] spk_idx;
  logic             busy;
  logic             sweep_done;
  logic             overrun;
  logic [IDX_W-1:0] rd_idx = '0;
  logic [W-1:0]     rd_state;

  lif_scheduler #(
    .N_NEURONS     (N),
    .WIDTH         (W),
    .REFRAC_SWEEPS (REFRAC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_idx         (in_idx),
    .in_current     (in_current),
    .tick           (tick),
    .cfg_threshold  (cfg_threshold),
    .cfg_leak_shift (cfg_leak_shift),
    .spk_valid      (spk_valid),
    .spk_ready      (spk_ready),
    .spk_idx        (spk_idx),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .overrun        (overrun),
    .rd_idx         (rd_idx),
    .rd_state       (rd_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: membrane values, pending currents, refractory sweeps left.
  int m_v    [N];
  int m_pend [N];
  int m_ref  [N];
  int exp_q  [$];

  typedef struct {
    int idx;
    int cur_a;
    int cur_b;
    int shift;
    int thr;
    int exp_v;
    int exp_spk;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i]    = 0;
      m_pend[i] = 0;
      m_ref[i]  = 0;
    end
  endtask

  task automatic model_sweep();
    int leaked;
    int sum;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
`ifdef LIF_REFRACTORY_EN
      if (m_ref[i] > 0) begin
        m_ref[i]  = m_ref[i] - 1;
        m_v[i]    = 0;
        m_pend[i] = 0;
        continue;
      end
`endif
      if (cfg_leak_shift == 3'd0) leaked = m_v[i];
      else leaked = m_v[i] - m_v[i] / (1 << int'(cfg_leak_shift));
      sum = leaked + m_pend[i];
      if (sum > MAXV) sum = MAXV;
      m_pend[i] = 0;
      if (sum >= int'(cfg_threshold)) begin
        exp_q.push_back(i);
        m_v[i]   = 0;
        m_ref[i] = REFRAC;
      end else begin
        m_v[i] = sum;
      end
    end
  endtask

  task automatic reset_dut();
    in_valid  = 1'b0;
    tick      = 1'b0;
    spk_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic send(input int idx, input int cur);
    int n;
    n          = 0;
    in_idx     = IDX_W'(idx);
    in_current = W'(cur);
    in_valid   = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual in_ready=0 required 1 within 100 cycles");
    end
    step();
    in_valid = 1'b0;
    m_pend[idx] = (m_pend[idx] + cur > MAXV) ? MAXV : m_pend[idx] + cur;
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      rd_idx = IDX_W'(i);
      step();
      check($sformatf("rd_state[%0d]", i), 32'(rd_state), m_v[i]);
    end
  endtask

  // mode 0: spk_ready held high; mode 1: random spk_ready. hold: initial cycles with spk_ready low.
  task automatic do_sweep(input int mode, input int hold, output int nspk, output int cyc);
    int got [$];
    int lim;
    model_sweep();
    spk_ready = (hold > 0) ? 1'b0 : 1'b1;
    tick = 1'b1;
    #1;
    check("in_ready_on_tick", 32'(in_ready), 0);
    check("busy_before_tick", 32'(busy), 0);
    step();
    tick = 1'b0;
    cyc  = 0;
    forever begin
      if (sweep_done) spk_ready = 1'b1;
      else if (cyc < hold) spk_ready = 1'b0;
      else if (mode == 1) spk_ready = 1'($urandom_range(0, 1));
      else spk_ready = 1'b1;
      if (cyc == 0) begin
        check("busy_in_sweep", 32'(busy), 1);
        check("in_ready_in_sweep", 32'(in_ready), 0);
      end
      if (hold > 0 && cyc == hold - 1) begin
        check("stall_busy", 32'(busy), 1);
        check("stall_spk_valid", 32'(spk_valid), 1);
        check("stall_spk_idx", 32'(spk_idx), 0);
        check("stall_no_done", 32'(sweep_done), 0);
      end
      if (spk_valid && spk_ready) got.push_back(int'(spk_idx));
      if (sweep_done) break;
      if (cyc >= 200) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout: actual no sweep_done after %0d cycles required done", cyc);
        break;
      end
      step();
      cyc++;
    end
    step();
    check("spk_drained", 32'(spk_valid), 0);
    check("done_pulse_width", 32'(sweep_done), 0);
    check("busy_after_sweep", 32'(busy), 0);
    nspk = got.size();
    check("spike_count", 32'(got.size()), 32'(exp_q.size()));
    lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      check($sformatf("spike_order[%0d]", i), 32'(got[i]), 32'(exp_q[i]));
    end
    if (mode == 0 && hold == 0) check("sweep_len", 32'(cyc), N);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nspk;
    int cyc;
    int n;

    vecs[0] = '{2,  60,  50, 0, 100,  0, 1};
    vecs[1] = '{0,  80,   0, 1, 255, 40, 0};
    vecs[2] = '{3,  80,  10, 2, 255, 70, 0};
    vecs[3] = '{1, 200, 200, 0, 255,  0, 1};
    vecs[4] = '{1, 200, 100, 0,   0,  0, 4};
    vecs[5] = '{0, 100,   0, 7, 255, 100, 0};
    vecs[6] = '{2, 254,   1, 0, 255,  0, 1};
    vecs[7] = '{3, 127,   0, 1,  63,  0, 1};
    vecs[8] = '{1, 127,   0, 1,  65, 64, 0};

    // Reset state
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_spk_valid", 32'(spk_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_rd_state", 32'(rd_state), 0);
    reset_dut();
    read_all();

    // Vector table: prime one neuron, then one configured sweep
    for (int k = 0; k < 9; k++) begin
      reset_dut();
      cfg_threshold  = 8'd255;
      cfg_leak_shift = 3'd0;
      send(vecs[k].idx, vecs[k].cur_a);
      do_sweep(0, 0, nspk, cyc);
      cfg_leak_shift = 3'(vecs[k].shift);
      cfg_threshold  = W'(vecs[k].thr);
      if (vecs[k].cur_b > 0) send(vecs[k].idx, vecs[k].cur_b);
      do_sweep(0, 0, nspk, cyc);
      check($sformatf("vec%0d_spikes", k), 32'(nspk), vecs[k].exp_spk);
      rd_idx = IDX_W'(vecs[k].idx);
      step();
      check($sformatf("vec%0d_state", k), 32'(rd_state), vecs[k].exp_v);
      read_all();
    end

    // Leak over two sweeps
    reset_dut();
    cfg_threshold  = 8'd255;
    cfg_leak_shift = 3'd0;
    send(0, 80);
    do_sweep(0, 0, nspk, cyc);
    cfg_leak_shift = 3'd1;
    do_sweep(0, 0, nspk, cyc);
    rd_idx = '0;
    step();
    check("leak_first", 32'(rd_state), 40);
    do_sweep(0, 0, nspk, cyc);
    rd_idx = '0;
    step();
    check("leak_second", 32'(rd_state), 20);

    // Pending saturation
    reset_dut();
    cfg_leak_shift = 3'd0;
    cfg_threshold  = 8'd255;
    send(1, 200);
    send(1, 200);
    do_sweep(0, 0, nspk, cyc);
    check("sat_spikes", 32'(nspk), 1);
    read_all();

    // Backpressure stalls the sweep
    reset_dut();
    cfg_threshold = 8'd1;
    for (int i = 0; i < N; i++) send(i, 5);
    do_sweep(0, 6, nspk, cyc);
    check("bp_spikes", 32'(nspk), 4);
    check("bp_len", 32'(cyc), N + 5);
    read_all();

    // Input held across a tick is accepted only after the sweep
    reset_dut();
    cfg_threshold = 8'd255;
    in_idx        = 2'd3;
    in_current    = 8'd30;
    in_valid      = 1'b1;
    do_sweep(0, 0, nspk, cyc);
    in_valid  = 1'b0;
    m_pend[3] = 30;
    do_sweep(0, 0, nspk, cyc);
    rd_idx = 2'd3;
    step();
    check("held_input_state", 32'(rd_state), 30);

    // Overrun: extra tick while busy is sticky and does not restart the sweep
    reset_dut();
    cfg_threshold = 8'd255;
    send(1, 60);
    check("overrun_clear", 32'(overrun), 0);
    model_sweep();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    cyc = 2;
    check("overrun_set", 32'(overrun), 1);
    while (!sweep_done && cyc < 50) begin
      step();
      cyc++;
    end
    check("overrun_sweep_len", 32'(cyc), N);
    step();
    step();
    check("overrun_no_restart", 32'(busy), 0);
    check("overrun_sticky", 32'(overrun), 1);
    rd_idx = 2'd1;
    step();
    check("overrun_state", 32'(rd_state), 60);
    read_all();

`ifdef LIF_REFRACTORY_EN
    // Refractory: two discarded sweeps after a spike
    reset_dut();
    cfg_threshold = 8'd100;
    send(0, 150);
    do_sweep(0, 0, nspk, cyc);
    check("ref_first_spike", 32'(nspk), 1);
    for (int s = 0; s < 2; s++) begin
      send(0, 200);
      do_sweep(0, 0, nspk, cyc);
      check("ref_no_spike", 32'(nspk), 0);
      rd_idx = '0;
      step();
      check("ref_held_zero", 32'(rd_state), 0);
    end
    send(0, 60);
    do_sweep(0, 0, nspk, cyc);
    rd_idx = '0;
    step();
    check("ref_integrates", 32'(rd_state), 60);
`endif

    // Asynchronous reset in the middle of a stalled sweep
    reset_dut();
    cfg_threshold = 8'd1;
    send(0, 5);
    send(1, 5);
    spk_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("mid_busy", 32'(busy), 1);
    check("mid_overrun", 32'(overrun), 1);
    check("mid_spk_valid", 32'(spk_valid), 1);
    rst_n = 1'b0;
    #2;
    check("arst_busy", 32'(busy), 0);
    check("arst_spk_valid", 32'(spk_valid), 0);
    check("arst_overrun", 32'(overrun), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_rd_state", 32'(rd_state), 0);
    rst_n     = 1'b1;
    spk_ready = 1'b1;
    model_clear();
    read_all();
    do_sweep(0, 0, nspk, cyc);
    check("arst_pending_cleared", 32'(nspk), 0);

    // Random traffic against the reference model
    reset_dut();
    for (int it = 0; it < 30; it++) begin
      cfg_leak_shift = 3'($urandom_range(0, 7));
      cfg_threshold  = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom_range(20, 255));
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) send($urandom_range(0, N - 1), $urandom_range(0, 255));
      do_sweep($urandom_range(0, 1), 0, nspk, cyc);
      read_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_scheduler.md
Name: lif_scheduler

Overview:
- Time-multiplexes one leaky integrate-and-fire update datapath across N_NEURONS virtual neurons. Membrane states and pending input currents are held in internal register arrays.
- Input currents are accepted per neuron index over a valid/ready handshake.
- A `tick` starts one sweep that updates every neuron in index order.
- Spikes leave as indexed events through a one-entry valid/ready output buffer. The block sits between the top-level pin wrapper and the neuron datapath.

Parameters:
- N_NEURONS, 4, number of virtual neurons (power of two, 2..16)
- WIDTH, 8, membrane state / current width
- IDX_W, $clog2(N_NEURONS), neuron index width (derived localparam, not overridable)
- REFRAC_SWEEPS, 2, refractory length in sweeps (used only with LIF_REFRACTORY_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input current valid
- in_ready  out  1  input current accepted when in_valid && in_ready
- in_idx  in  IDX_W  target neuron
- in_current  in  WIDTH  unsigned current to add
- tick  in  1  single-cycle sweep request
- cfg_threshold  in  WIDTH  spike threshold
- cfg_leak_shift  in  3  leak shift; 0 disables leak
- spk_valid  out  1  spike event valid
- spk_ready  in  1  spike event consumed
- spk_idx  out  IDX_W  index of spiking neuron
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of sweep
- overrun  out  1  sticky: tick arrived while busy
- rd_idx  in  IDX_W  readback select
- rd_state  out  WIDTH  membrane state of rd_idx, registered (one-cycle latency)

Behaviour:
- **Reset.** Asynchronous reset, active low. All states, pending currents, refractory counters and `rd_state` are 0. `spk_valid`, `busy`, `sweep_done` and `overrun` are 0. FSM is IDLE.
- **FSM states.** IDLE, SWEEP.
- **IDLE.**
  - `in_ready = !tick` (combinational).
  - On an accepted input, `pending[in_idx] = sat(pending[in_idx] + in_current)`, saturating at 2^WIDTH-1.
  - When `tick` is high: go to SWEEP, set `ptr = 0`, `busy = 1`. A `tick` and `in_valid` in the same cycle gives no handshake; the input must be held.
- **SWEEP.**
  - `in_ready = 0`.
  - Each cycle, neuron `ptr` is updated unless stalled.
  - Stall condition: `spk_valid && !spk_ready`. The stall holds regardless of whether the current neuron would spike, so spike order equals index order.
- **Update (per neuron, one cycle).**
  - leaked = v - (v >> shift) for shift 1..7; leaked = v for shift 0.
  - sum = leaked + pending, computed in WIDTH+1 bits, saturated to WIDTH bits.
  - If sum >= cfg_threshold: spike, v = 0.
  - Otherwise v = sum.
  - pending[ptr] = 0.
  - A spike loads `spk_idx = ptr` and `spk_valid = 1` in the same edge that writes v.
  - cfg_threshold = 0 makes every updated neuron spike.
- **Sweep end.**
  - After updating `ptr == N_NEURONS-1`: FSM returns to IDLE, `busy` falls, and `sweep_done` pulses for one cycle in that first IDLE cycle.
  - Minimum sweep length is N_NEURONS cycles plus stall cycles.
- **Spike output.**
  - `spk_valid` stays high with a stable `spk_idx` until `spk_ready`.
  - The buffer is cleared on the accepting edge unless a new spike loads it in the same edge.
  - Spikes may drain after `sweep_done`.
- **Overrun.** `tick` while `busy` is ignored for sequencing and sets `overrun`, which stays set until reset.
- **Config sampling.** `cfg_*` are sampled every update cycle; changing them mid-sweep affects only the remaining neurons.
- **Reset mid-sweep.** Aborts immediately to the reset values; pending spikes are lost.
- **Readback.** `rd_state` reflects the array value as of the previous edge (write-then-read ordering: the registered read sees the old value in the write cycle).

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- **With the macro:** each neuron has a counter sized for REFRAC_SWEEPS, loaded to REFRAC_SWEEPS on a spike.
  - While the counter is nonzero, the neuron's update cycle discards pending (clears it), holds v = 0, never spikes, and decrements the counter.
  - Inputs are still accepted into pending.
- **Without the macro:** no counters; a neuron integrates normally on the sweep after a spike.

Decomposition:
- Package lif_pkg:
  - FSM state enum (IDLE, SWEEP)
  - leak-shift width constant (3)
  - saturating-add function, parameterised by width
- Sub-module lif_update: purely combinational.
  - Inputs: v, pending, threshold, shift, refractory-active flag.
  - Outputs: v_next, spike.
  - Instantiated once.
- lif_scheduler holds the arrays, FSM, handshakes and readback.

Test Plan:
- **Reset.** Assert rst_n=0 mid-operation -> `busy=0`, `spk_valid=0`, `overrun=0`, `in_ready=1`, `rd_state=0` for all indices.
- **Integrate and spike.** shift=0, thr=100; inject 60 to idx 2, tick -> `rd_state[2]=60`, no spike. Inject 50, tick -> spike with `spk_idx=2`, `rd_state[2]=0`.
- **Leak.** shift=1, thr=255; state[0]=80, no input; two ticks -> 40, then 20. `sweep_done` pulses exactly N_NEURONS cycles after each tick.
- **Saturation.** Inject 200 twice to idx 1 -> pending 255. thr=255, tick -> spike `spk_idx=1`.
- **Backpressure.** thr=1, inject 5 to all four neurons, spk_ready=0 for 6 cycles after tick -> sweep stalls with `busy=1`. Spikes delivered in order 0,1,2,3; `sweep_done` follows the last update.
- **Overrun/refractory.** Tick while busy -> `overrun=1` sticky, sweep result unchanged. With LIF_REFRACTORY_EN and REFRAC_SWEEPS=2: a spiking neuron given input 200 stays 0 with no spike for the next two sweeps, then integrates.
